// File: rtl/serdes_seq_pkg.sv
// rtl/serdes_seq_pkg.sv - shared types, width limits and width check for the serdes tx sequencer
package serdes_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ALIGN  = 2'd2,
        RUN    = 2'd3
    } seq_state_t;

    localparam logic [3:0] WIDTH_MIN = 4'd3;
    localparam logic [3:0] WIDTH_MAX = 4'd10;

    // A serialization ratio the word counter and core clock divider can honour.
    function automatic logic width_legal(input logic [3:0] width);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serdes_tx_sequencer_if.sv
// rtl/serdes_tx_sequencer_if.sv - per-lane enable/valid/load/underflow bundle
interface serdes_tx_sequencer_if #(
    parameter int NUM_LANES = 4
);
    logic [NUM_LANES-1:0] lane_en;
    logic [NUM_LANES-1:0] lane_valid;
    logic                 underflow_clr;
    logic [NUM_LANES-1:0] lane_load;
    logic [NUM_LANES-1:0] underflow;

    // Lane side: supplies enables, word availability and the flag clear.
    modport master (
        output lane_en,
        output lane_valid,
        output underflow_clr,
        input  lane_load,
        input  underflow
    );

    // Sequencer side: gates the loads and reports starved lanes.
    modport slave (
        input  lane_en,
        input  lane_valid,
        input  underflow_clr,
        output lane_load,
        output underflow
    );
endinterface

// File: rtl/serdes_seq_lane_mon.sv
// rtl/serdes_seq_lane_mon.sv - one lane's load gating and sticky underflow flag
module serdes_seq_lane_mon (
    input  logic clk,
    input  logic reset,
    input  logic word_load,
    input  logic lane_en,
    input  logic lane_valid,
    input  logic underflow_clr,
    output logic lane_load,
    output logic underflow
);

    logic starved;

    assign lane_load = word_load & lane_en & lane_valid;
    assign starved   = word_load & lane_en & ~lane_valid;

    // Sticky flag: a starved load slot sets it and beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underflow <= 1'b0;
        end else if (starved) begin
            underflow <= 1'b1;
        end else if (underflow_clr) begin
            underflow <= 1'b0;
        end
    end

endmodule

// File: rtl/serdes_tx_sequencer.sv
// rtl/serdes_tx_sequencer.sv - PLL settle, bond alignment and word-slot sequencing for tx lanes
module serdes_tx_sequencer
    import serdes_seq_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int LOCK_DELAY  = 256,
    parameter int BOND_MASTER = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pll_lock,
    input  logic [3:0]           cfg_width,
    input  logic                 bond_sync_in,
    output logic                 bond_sync_out,
    output logic                 core_clk,
    output logic                 word_load,
    output logic                 cfg_err,
    output logic [1:0]           state,
    output logic                 running,
    serdes_tx_sequencer_if.slave lanes
);

    localparam int LCW = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_DELAY - 1);

    seq_state_t           state_q;
    seq_state_t           state_d;
    logic [LCW-1:0]       lock_cnt;
    logic [3:0]           word_cnt;
    logic [3:0]           width_q;
    logic [NUM_LANES-1:0] lane_load_w;
    logic [NUM_LANES-1:0] underflow_w;

    // Next state and all state-derived outputs; lock loss wins over every advance.
    always_comb begin
        state_d       = state_q;
        bond_sync_out = 1'b0;
        core_clk      = 1'b0;
        word_load     = 1'b0;
        cfg_err       = 1'b0;
        running       = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_err = !width_legal(cfg_width);
                if (pll_lock && width_legal(cfg_width)) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!pll_lock) begin
                    state_d = IDLE;
                end else if (lock_cnt == LOCK_LAST) begin
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                bond_sync_out = (BOND_MASTER != 0);
                if (!pll_lock) begin
                    state_d = IDLE;
                end else if ((BOND_MASTER != 0) || bond_sync_in) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                running   = 1'b1;
                word_load = (word_cnt == width_q - 4'd1);
                core_clk  = (word_cnt < (width_q >> 1));
                if (!pll_lock) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Width latch on IDLE exit, settle counter, and the word slot counter that restarts at RUN entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            width_q  <= WIDTH_MIN;
            lock_cnt <= '0;
            word_cnt <= '0;
        end else begin
            if ((state_q == IDLE) && (state_d == SETTLE)) begin
                width_q <= cfg_width;
            end
            if ((state_q == SETTLE) && (state_d == SETTLE)) begin
                lock_cnt <= lock_cnt + LCW'(1);
            end else begin
                lock_cnt <= '0;
            end
            if ((state_q == RUN) && (state_d == RUN)) begin
                word_cnt <= (word_cnt == width_q - 4'd1) ? 4'd0 : word_cnt + 4'd1;
            end else begin
                word_cnt <= '0;
            end
        end
    end

    assign state = state_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        serdes_seq_lane_mon u_mon (
            .clk           (clk),
            .reset         (reset),
            .word_load     (word_load),
            .lane_en       (lanes.lane_en[i]),
            .lane_valid    (lanes.lane_valid[i]),
            .underflow_clr (lanes.underflow_clr),
            .lane_load     (lane_load_w[i]),
            .underflow     (underflow_w[i])
        );
    end

    assign lanes.lane_load = lane_load_w;
    assign lanes.underflow = underflow_w;

endmodule

// File: tb/tb_serdes_tx_sequencer.sv
// tb/tb_serdes_tx_sequencer.sv - bonded master/slave pair checked against a lock-age model
module tb_serdes_tx_sequencer;

    localparam int NL  = 4;
    localparam int LDM = 8;
    localparam int LDS = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pll_lock = 1'b0;
    logic [3:0]    cfg_width = 4'd4;
    logic [NL-1:0] lane_en = '1;
    logic [NL-1:0] lane_valid = '1;
    logic          underflow_clr = 1'b0;

    logic          m_bs_out, m_cc, m_wl, m_err, m_run;
    logic [1:0]    m_state;
    logic          s_bs_out, s_cc, s_wl, s_err, s_run;
    logic [1:0]    s_state;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    serdes_tx_sequencer_if #(.NUM_LANES(NL)) if_m ();
    serdes_tx_sequencer_if #(.NUM_LANES(NL)) if_s ();

    assign if_m.lane_en       = lane_en;
    assign if_m.lane_valid    = lane_valid;
    assign if_m.underflow_clr = underflow_clr;
    assign if_s.lane_en       = lane_en;
    assign if_s.lane_valid    = lane_valid;
    assign if_s.underflow_clr = underflow_clr;

    serdes_tx_sequencer #(.NUM_LANES(NL), .LOCK_DELAY(LDM), .BOND_MASTER(1)) u_master (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .cfg_width(cfg_width),
        .bond_sync_in(1'b0), .bond_sync_out(m_bs_out), .core_clk(m_cc),
        .word_load(m_wl), .cfg_err(m_err), .state(m_state), .running(m_run),
        .lanes(if_m.slave)
    );

    serdes_tx_sequencer #(.NUM_LANES(NL), .LOCK_DELAY(LDS), .BOND_MASTER(0)) u_slave (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .cfg_width(cfg_width),
        .bond_sync_in(m_bs_out), .bond_sync_out(s_bs_out), .core_clk(s_cc),
        .word_load(s_wl), .cfg_err(s_err), .state(s_state), .running(s_run),
        .lanes(if_s.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: 'since' counts cycles since the pair left IDLE together (-1 while idle).
    int            since = -1;
    int            wq = 3;
    logic [NL-1:0] uf_m = '0;
    logic [NL-1:0] uf_s = '0;

    always @(negedge clk) begin
        int st_m, st_s, ph;
        logic wl, cc, legal;
        if (!reset) begin
            since = -1;
            wq    = 3;
            uf_m  = '0;
            uf_s  = '0;
        end
        legal = (cfg_width >= 3) && (cfg_width <= 10);
        wl = 1'b0;
        cc = 1'b0;
        if (since < 0)          st_m = 0;
        else if (since < LDM)   st_m = 1;
        else if (since == LDM)  st_m = 2;
        else                    st_m = 3;
        if (since < 0)          st_s = 0;
        else if (since < LDS)   st_s = 1;
        else if (since <= LDM)  st_s = 2;
        else                    st_s = 3;
        if (st_m == 3) begin
            ph = (since - LDM - 1) % wq;
            wl = (ph == wq - 1);
            cc = (ph < wq / 2);
        end
        chk("m_state", m_state, st_m);
        chk("s_state", s_state, st_s);
        chk("m_running", m_run, st_m == 3);
        chk("s_running", s_run, st_s == 3);
        chk("m_word_load", m_wl, wl);
        chk("s_word_load", s_wl, wl);
        chk("m_core_clk", m_cc, cc);
        chk("s_core_clk", s_cc, cc);
        chk("m_bond_sync_out", m_bs_out, st_m == 2);
        chk("s_bond_sync_out", s_bs_out, 0);
        chk("m_cfg_err", m_err, (st_m == 0) && !legal);
        chk("s_cfg_err", s_err, (st_s == 0) && !legal);
        chk("m_lane_load", if_m.lane_load, wl ? (lane_en & lane_valid) : '0);
        chk("s_lane_load", if_s.lane_load, wl ? (lane_en & lane_valid) : '0);
        chk("m_underflow", if_m.underflow, uf_m);
        chk("s_underflow", if_s.underflow, uf_s);
        if (reset) begin
            uf_m = (underflow_clr ? '0 : uf_m) | (wl ? (lane_en & ~lane_valid) : '0);
            uf_s = (underflow_clr ? '0 : uf_s) | (wl ? (lane_en & ~lane_valid) : '0);
            if (!pll_lock) begin
                since = -1;
            end else if (since < 0) begin
                if (legal) begin
                    since = 0;
                    wq    = int'(cfg_width);
                end
            end else begin
                since++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic goto(input int k);
        while (cyc_n < k) tick();
    endtask

    task automatic start_lock();
        pll_lock = 1'b1;
        cyc_n    = 0;
    endtask

    initial begin
        int n;
        repeat (3) tick();
        chk("reset_state", m_state, 0);
        chk("reset_core_clk", m_cc, 0);
        chk("reset_underflow", if_m.underflow, 0);
        reset = 1'b1;
        repeat (2) tick();

        // Width 4: settle 8, align 1, RUN from cycle 10, loads at 13 + 4k.
        start_lock();
        goto(9);  chk("t1_align_c9", m_state, 2); chk("t1_sync_c9", m_bs_out, 1);
        chk("t1_slave_align_c9", s_state, 2);
        goto(10); chk("t1_run_c10", m_state, 3); chk("t1_slave_run_c10", s_state, 3);
        chk("t1_cc_c10", m_cc, 1); chk("t1_wl_c10", m_wl, 0);
        goto(11); chk("t1_cc_c11", m_cc, 1);
        goto(12); chk("t1_cc_c12", m_cc, 0); chk("t1_wl_c12", m_wl, 0);
        goto(13); chk("t1_cc_c13", m_cc, 0); chk("t1_wl_c13", m_wl, 1);
        chk("t1_slave_wl_c13", s_wl, 1);
        goto(17); lane_valid = 4'b1011; #1;
        chk("t1_lane_load_c17", if_m.lane_load, 4'b1011);
        goto(18); lane_valid = '1; chk("t1_uf_set_c18", if_m.underflow, 4'b0100);
        goto(21); lane_valid = 4'b1011; underflow_clr = 1'b1;
        goto(22); lane_valid = '1; underflow_clr = 1'b0;
        chk("t1_uf_set_wins_c22", if_m.underflow, 4'b0100);
        goto(23); underflow_clr = 1'b1;
        goto(24); underflow_clr = 1'b0; chk("t1_uf_clr_c24", if_m.underflow, 0);
        goto(29); lane_valid = 4'b1011;
        goto(30); lane_valid = '1; chk("t1_uf_again_c30", if_m.underflow, 4'b0100);
        goto(32); pll_lock = 1'b0;
        goto(33); chk("t1_drop_state", m_state, 0); chk("t1_drop_cc", m_cc, 0);
        chk("t1_drop_wl", m_wl, 0); chk("t1_drop_uf_kept", if_m.underflow, 4'b0100);
        tick();

        // Width 5: core_clk 11000, period 5; a width change in RUN is ignored.
        cfg_width = 4'd5;
        tick();
        start_lock();
        goto(10); chk("t2_cc_c10", m_cc, 1);
        goto(11); chk("t2_cc_c11", m_cc, 1);
        goto(12); chk("t2_cc_c12", m_cc, 0); cfg_width = 4'd7;
        goto(13); chk("t2_cc_c13", m_cc, 0); chk("t2_wl_c13", m_wl, 0);
        goto(14); chk("t2_cc_c14", m_cc, 0); chk("t2_wl_c14", m_wl, 1);
        goto(15); chk("t2_cc_c15", m_cc, 1);
        goto(18); chk("t2_wl_c18", m_wl, 0);
        goto(19); chk("t2_wl_c19", m_wl, 1);
        pll_lock = 1'b0;
        tick();

        // Illegal widths hold IDLE with cfg_err; width 10 leaves on the next edge.
        cfg_width = 4'd2; pll_lock = 1'b1; #1;
        chk("t3_err_w2", m_err, 1);
        tick(); tick(); chk("t3_idle_w2", m_state, 0);
        cfg_width = 4'd11; #1; chk("t3_err_w11", m_err, 1);
        tick(); chk("t3_idle_w11", m_state, 0);
        cfg_width = 4'd10; #1; chk("t3_err_w10", m_err, 0);
        tick(); chk("t3_settle_w10", m_state, 1); chk("t3_err_settle", m_err, 0);
        tick(); tick();

        // Asynchronous reset mid-SETTLE clears everything without waiting for an edge.
        #2 reset = 1'b0; #1;
        chk("t4_rst_state", m_state, 0); chk("t4_rst_slave_state", s_state, 0);
        chk("t4_rst_uf", if_m.underflow, 0); chk("t4_rst_cc", m_cc, 0);
        pll_lock = 1'b0;
        tick(); reset = 1'b1;
        tick();

        // Random episodes: random widths (some illegal), lane patterns, clears and lock drops.
        for (int ep = 0; ep < 70; ep++) begin
            cfg_width = ($urandom % 5 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(3, 10));
            pll_lock  = 1'b1;
            n = $urandom_range(4, 70);
            for (int k = 0; k < n; k++) begin
                lane_en       = 4'($urandom);
                lane_valid    = 4'($urandom) | 4'($urandom);
                underflow_clr = ($urandom % 12 == 0);
                if ($urandom % 20 == 0) cfg_width = 4'($urandom_range(3, 10));
                tick();
            end
            pll_lock = 1'b0;
            tick();
            if ($urandom % 3 == 0) tick();
        end
        underflow_clr = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
